// File: rtl/regfile.sv
// 64 x 32 flop register file with one scalar write port, a four-lane vector write port,
// three combinational read ports, and a self-clearing sequence after reset.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        regwrite,
    input  logic [5:0]  rd,
    input  logic [31:0] regwdata,
    input  logic        vec_regwrite,
    input  logic [5:0]  rd2,
    input  logic [5:0]  rd3,
    input  logic [5:0]  rd4,
    input  logic [5:0]  rd5,
    input  logic [31:0] regwdata2,
    input  logic [31:0] regwdata3,
    input  logic [31:0] regwdata4,
    input  logic [31:0] regwdata5,
    input  logic [5:0]  rs1,
    input  logic [5:0]  rs2,
    input  logic [5:0]  rs3,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] rdata3
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [64];
    logic [31:0] mem_d [64];
    logic        accept;
    logic        clearing;
    logic [5:0]  lane_addr [4];
    logic [31:0] lane_data [4];
    logic [5:0]  rs_addr [3];
    logic [31:0] rd_val [3];

    // rst masks everything in the cycle it is asserted, not just from the next edge
    assign accept   = (state_q == RUN) && !rst;
    assign clearing = (state_q == CLEAR) && !rst;
    assign ready    = accept;

    assign lane_addr[0] = rd2;
    assign lane_addr[1] = rd3;
    assign lane_addr[2] = rd4;
    assign lane_addr[3] = rd5;
    assign lane_data[0] = regwdata2;
    assign lane_data[1] = regwdata3;
    assign lane_data[2] = regwdata4;
    assign lane_data[3] = regwdata5;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clearing) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
                state_d = RUN;
            end
        end
    end

    // Later assignments override earlier ones: lane 0 < lane 3 < scalar
    always_comb begin
        mem_d = mem_q;
        if (clearing) begin
            mem_d[cnt_q] = '0;
        end else if (accept) begin
            if (vec_regwrite) begin
                for (int i = 0; i < 4; i++) begin
                    mem_d[lane_addr[i]] = lane_data[i];
                end
            end
            if (regwrite) begin
                mem_d[rd] = regwdata;
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        mem_q <= mem_d;
    end

    assign rs_addr[0] = rs1;
    assign rs_addr[1] = rs2;
    assign rs_addr[2] = rs3;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_read
            logic [31:0] val;
            always_comb begin
                val = '0;
                if (accept && (rs_addr[gi] != 6'd0)) begin
                    val = mem_q[rs_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                    if (vec_regwrite) begin
                        for (int i = 0; i < 4; i++) begin
                            if (lane_addr[i] == rs_addr[gi]) begin
                                val = lane_data[i];
                            end
                        end
                    end
                    if (regwrite && (rd == rs_addr[gi])) begin
                        val = regwdata;
                    end
`endif
                end
            end
            assign rd_val[gi] = val;
        end
    endgenerate

    assign rdata1 = rd_val[0];
    assign rdata2 = rd_val[1];
    assign rdata3 = rd_val[2];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: clear sequence, scalar/vector writes,
// write priority, reset mid-clear and same-cycle forwarding in either build.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        regwrite;
    logic [5:0]  rd;
    logic [31:0] regwdata;
    logic        vec_regwrite;
    logic [5:0]  rd2, rd3, rd4, rd5;
    logic [31:0] regwdata2, regwdata3, regwdata4, regwdata5;
    logic [5:0]  rs1, rs2, rs3;
    logic [31:0] rdata1, rdata2, rdata3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk(clk), .rst(rst), .ready(ready),
        .regwrite(regwrite), .rd(rd), .regwdata(regwdata),
        .vec_regwrite(vec_regwrite),
        .rd2(rd2), .rd3(rd3), .rd4(rd4), .rd5(rd5),
        .regwdata2(regwdata2), .regwdata3(regwdata3),
        .regwdata4(regwdata4), .regwdata5(regwdata5),
        .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Deasserts rst at the current negedge and counts cycles until ready rises
    task automatic count_clear(input string tag);
        int n = 0;
        bit rd_nonzero = 0;
        rst = 1'b0;
        #1;
        while (ready !== 1'b1 && n < 200) begin
            if (rdata1 !== 32'h0) rd_nonzero = 1;
            n++;
            tick();
            #1;
        end
        check_eq(tag, n, 32'd64);
        check_eq({tag, "_rd0"}, {31'h0, rd_nonzero}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; regwrite = 0; rd = 0; regwdata = 0; vec_regwrite = 0;
        rd2 = 0; rd3 = 0; rd4 = 0; rd5 = 0;
        regwdata2 = 0; regwdata3 = 0; regwdata4 = 0; regwdata5 = 0;
        rs1 = 5; rs2 = 0; rs3 = 0;
        tick(); tick(); #1;
        check_eq("rst_ready", {31'h0, ready}, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);

        // Clear with writes hammering entry 5 the whole time
        tick();
        regwrite = 1; rd = 5; regwdata = 32'h1234;
        count_clear("clear_len");
        regwrite = 0;
        rs1 = 5; rs2 = 63; #1;
        check_eq("clear_e5", rdata1, 32'h0);
        check_eq("clear_e63", rdata2, 32'h0);

        // Scalar write
        tick();
        regwrite = 1; rd = 10; regwdata = 32'hDEADBEEF; rs2 = 10;
        tick();
        regwrite = 0; #1;
        check_eq("scalar_e10", rdata2, 32'hDEADBEEF);

        // Entry 0 stays zero, and is never forwarded
        regwrite = 1; rd = 0; regwdata = 32'hFFFFFFFF; rs1 = 0; #1;
        check_eq("e0_same_cycle", rdata1, 32'h0);
        tick();
        regwrite = 0; #1;
        check_eq("e0_after", rdata1, 32'h0);

        // Vector plus scalar collision
        vec_regwrite = 1; rd2 = 20; rd3 = 21; rd4 = 20; rd5 = 22;
        regwdata2 = 32'hA; regwdata3 = 32'hB; regwdata4 = 32'hC; regwdata5 = 32'hD;
        regwrite = 1; rd = 22; regwdata = 32'hE;
        tick();
        vec_regwrite = 0; regwrite = 0;
        rs1 = 20; rs2 = 21; rs3 = 22; #1;
        check_eq("vec_e20", rdata1, 32'hC);
        check_eq("vec_e21", rdata2, 32'hB);
        check_eq("vec_e22", rdata3, 32'hE);

        // All four lanes on one address: lane 3 wins
        vec_regwrite = 1; rd2 = 30; rd3 = 30; rd4 = 30; rd5 = 30;
        regwdata2 = 32'h1; regwdata3 = 32'h2; regwdata4 = 32'h3; regwdata5 = 32'h4;
        tick();
        vec_regwrite = 0; rs1 = 30; rs2 = 30; #1;
        check_eq("lane3_wins", rdata1, 32'h4);
        check_eq("same_addr_2ports", rdata2, 32'h4);

        // Bit-exact storage in the top entry
        regwrite = 1; rd = 63; regwdata = 32'h80000001;
        tick();
        regwrite = 0; rs3 = 63; #1;
        check_eq("bitexact_e63", rdata3, 32'h80000001);

        // Forwarding: old value 0x11, then write 0x55 while reading
        regwrite = 1; rd = 7; regwdata = 32'h11;
        tick();
        regwdata = 32'h55; rs3 = 7; #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("bypass_same", rdata3, 32'h55);
`else
        check_eq("bypass_same", rdata3, 32'h11);
`endif
        tick();
        regwrite = 0; #1;
        check_eq("bypass_next", rdata3, 32'h55);

        // rst in RUN masks ready and reads immediately
        rst = 1; rs1 = 63; #1;
        check_eq("rst_run_ready", {31'h0, ready}, 32'h0);
        check_eq("rst_run_rdata", rdata1, 32'h0);
        tick();

        // Reset at clear counter 30: 30 edges after deassert, then re-assert
        rst = 0;
        repeat (30) tick();
        #1;
        check_eq("midclear_ready", {31'h0, ready}, 32'h0);
        check_eq("midclear_e63", rdata1, 32'h0);
        rst = 1;
        tick();
        count_clear("midclear_len");
        rs1 = 63; rs2 = 7; rs3 = 10; #1;
        check_eq("reclear_e63", rdata1, 32'h0);
        check_eq("reclear_e7", rdata2, 32'h0);
        check_eq("reclear_e10", rdata3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset; all ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ready  out  1  high when the clear sequence is complete and writes are accepted.
REQ-005 regwrite  in  1  scalar write enable.
REQ-006 rd  in  6  scalar write address.
REQ-007 regwdata  in  32  scalar write data.
REQ-008 vec_regwrite  in  1  vector write enable, which writes all four lanes.
REQ-009 rd2, rd3, rd4, rd5  in  6 each  lane 0..3 write addresses.
REQ-010 regwdata2, regwdata3, regwdata4, regwdata5  in  32 each  lane 0..3 write data.
REQ-011 rs1, rs2, rs3  in  6 each  scalar read addresses.
REQ-012 rdata1, rdata2, rdata3  out  32 each  combinational read data for rs1..rs3.

Function
REQ-013 Storage SHALL be 64 entries x 32 bits, held in flops.
REQ-014 Entry 0 SHALL always read 0, and writes to entry 0 SHALL be discarded.
REQ-015 FSM states SHALL be CLEAR and RUN, with a 6-bit clear counter.
- CLEAR: one entry is zeroed per cycle at counter index, counter increments.
- Transition: CLEAR -> RUN after index 63 is written.
REQ-016 rst SHALL force CLEAR with counter=0 on the next edge, from any state, including mid-clear.
REQ-017 ready SHALL be 0 in CLEAR and 1 in RUN; ready rises in the cycle after index 63 is cleared, 64 cycles after rst deasserts.
REQ-018 In CLEAR, regwrite and vec_regwrite SHALL be ignored (dropped, not queued), and rdata1..3 SHALL read 0.
REQ-019 In RUN, the write takes effect at the rising edge of the cycle in which the enable is sampled high, with 1-cycle write latency.
REQ-020 regwrite and vec_regwrite high in the same cycle SHALL perform both writes.
- Address collision between scalar and any lane: scalar data wins.
REQ-021 Vector lanes with equal addresses: the highest-numbered lane wins (lane 3 = rd5 > rd4 > rd3 > rd2).
REQ-022 Reads SHALL be purely combinational from the address inputs; any number of ports may read the same address.
REQ-023 No arithmetic: data is stored and returned bit-exact, with no sign or width conversion.

Reset
REQ-024 During rst high, ready SHALL be 0 and rdata1..3 SHALL be 0.
REQ-025 Entry contents are undefined only until the clear sequence overwrites them; no entry SHALL be readable as nonzero before ready=1.
REQ-026 No entry SHALL be written by the write ports between rst deassertion and ready=1.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
- Defined: in RUN, a read whose address matches an enabled, accepted write in the same cycle returns the write data combinationally, applying the REQ-020/021 priority; address 0 is never forwarded.
- Undefined: reads return stored contents only, so new data appears from the cycle after the write edge.
- The macro SHALL have no effect on port list, reset, or CLEAR behaviour.

Verification
REQ-028 Clear: pulse rst 1 cycle, then write every cycle with rd=5, data 0x1234 -> ready=0 for 64 cycles; reading rs1=5 after ready gives 0x00000000.
REQ-029 Scalar write: in RUN, regwrite=1, rd=10, regwdata=0xDEADBEEF; next cycle rs2=10 -> rdata2=0xDEADBEEF. Writing rd=0 with 0xFFFFFFFF -> rs1=0 reads 0.
REQ-030 Vector plus collision: vec_regwrite=1, rd2..rd5=20,21,20,22, data 0xA,0xB,0xC,0xD, with regwrite=1 rd=22 data 0xE -> entries 20=0xC, 21=0xB, 22=0xE.
REQ-031 Reset mid-clear: assert rst at clear counter 30 -> counter returns to 0; ready rises 64 cycles after this rst deasserts.
REQ-032 Bypass: regwrite rd=7 data 0x55 with rs3=7 in the same cycle -> rdata3=0x55 that cycle with REGFILE_BYPASS_EN, old value without it; 0x55 in the following cycle in both builds.
